// File: rtl/conv_capture_buffer.sv
// Capture buffer for convolution output words: delays the valid, skips SKIP_N words, stores the rest
// in RAM until fin. Define CAP_CHECKSUM_EN to add the cksum output (XOR of all stored words).
module conv_capture_buffer #(
    parameter int DATA_W    = 48,
    parameter int DEPTH     = 1025,
    parameter int ADDR_W    = 11,
    parameter int SKIP_N    = 1,
    parameter int ALIGN_DLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              fin,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
`ifdef CAP_CHECKSUM_EN
    output logic [DATA_W-1:0] cksum,
`endif
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [7:0]      SKIP_LD   = 8'(SKIP_N);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        skip_q, skip_d;
    logic              overflow_q, overflow_d;
    logic              take_word;
    logic              wr_en;
    logic              vd;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Valid alignment pipe; cap_data is deliberately not delayed.
    generate
        if (ALIGN_DLY == 0) begin : g_no_dly
            assign vd = cap_valid;
        end else begin : g_dly
            logic [ALIGN_DLY-1:0] pipe_q;
            for (genvar gi = 0; gi < ALIGN_DLY; gi++) begin : g_stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_q[gi] <= 1'b0;
                    end else if (arm) begin
                        pipe_q[gi] <= 1'b0;
                    end else begin
                        pipe_q[gi] <= (gi == 0) ? cap_valid : pipe_q[(gi == 0) ? 0 : gi-1];
                    end
                end
            end
            assign vd = pipe_q[ALIGN_DLY-1];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        skip_d     = skip_q;
        overflow_d = overflow_q;
        take_word  = 1'b0;
        wr_en      = 1'b0;
        if (arm) begin
            state_d    = ARMED;
            count_d    = '0;
            skip_d     = SKIP_LD;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    // An empty skip counter (SKIP_N=0) makes ARMED behave like CAPTURE.
                    if (skip_q == 8'd0) begin
                        state_d   = CAPTURE;
                        take_word = vd;
                    end else if (vd) begin
                        skip_d = skip_q - 8'd1;
                        if (skip_q == 8'd1) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: take_word = vd;
                default: ;
            endcase
            if (take_word) begin
                if (count_q < DEPTH_CNT) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (fin && (state_q == ARMED || state_q == CAPTURE)) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            skip_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            skip_q     <= skip_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM write port kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= cap_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en && ({1'b0, rd_addr} < count_q);
            if (rd_en) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

`ifdef CAP_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (arm) begin
            cksum_q <= '0;
        end else if (wr_en) begin
            cksum_q <= cksum_q ^ cap_data;
        end
    end

    assign cksum = cksum_q;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign busy     = (state_q == ARMED) || (state_q == CAPTURE);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_capture_buffer.sv
// Self-checking bench for conv_capture_buffer: capture sessions, overflow, restart, async reset,
// read-back through a table of vectors with a scoreboard queue.
module tb_conv_capture_buffer;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic          cap_valid;
    logic [DW-1:0] cap_data;
    logic          fin;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef CAP_CHECKSUM_EN
    logic [DW-1:0] cksum;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } rd_vec_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        int            addr;
    } exp_t;

    rd_vec_t vec_q[$];
    exp_t    sb_q[$];

    conv_capture_buffer #(
        .DATA_W(DW), .DEPTH(4), .ADDR_W(AW), .SKIP_N(1), .ALIGN_DLY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .cap_valid(cap_valid), .cap_data(cap_data),
        .fin(fin), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .busy(busy), .done(done),
`ifdef CAP_CHECKSUM_EN
        .cksum(cksum),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // cap_valid is raised one cycle before the data so the delayed valid lines up with it.
    task automatic send_word(input logic [DW-1:0] d, input logic with_fin);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        cap_data  = d;
        fin       = with_fin;
        tick();
        cap_data  = '0;
        fin       = 1'b0;
    endtask

    task automatic pulse_fin();
        fin = 1'b1;
        tick();
        fin = 1'b0;
    endtask

    task automatic add_vec(input int a, input logic v, input logic [DW-1:0] d);
        rd_vec_t r;
        r.addr      = AW'(a);
        r.exp_valid = v;
        r.exp_data  = d;
        vec_q.push_back(r);
    endtask

    task automatic apply_reads(input string tag);
        exp_t e;
        for (int i = 0; i < vec_q.size(); i++) begin
            rd_en   = 1'b1;
            rd_addr = vec_q[i].addr;
            e.v     = vec_q[i].exp_valid;
            e.d     = vec_q[i].exp_data;
            e.addr  = int'(vec_q[i].addr);
            sb_q.push_back(e);
            tick();
            e = sb_q.pop_front();
            chk($sformatf("%s_rd_valid[%0d]", tag, e.addr), 64'(rd_valid), 64'(e.v));
            if (e.v) begin
                chk($sformatf("%s_rd_data[%0d]", tag, e.addr), 64'(rd_data), 64'(e.d));
            end
        end
        rd_en = 1'b0;
        vec_q.delete();
    endtask

    initial begin
        logic [DW-1:0] last;
        rst_n = 1'b0; arm = 1'b0; cap_valid = 1'b0; cap_data = '0; fin = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // fin while IDLE must not leave IDLE
        pulse_fin();
        chk("idle_fin_done", 64'(done), 64'd0);

        // basic session: first word skipped, 2..5 stored
        pulse_arm();
        chk("s1_busy_armed", 64'(busy), 64'd1);
        for (int i = 1; i <= 5; i++) send_word(DW'(i), 1'b0);
        pulse_fin();
        chk("s1_count", 64'(count), 64'd4);
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_busy", 64'(busy), 64'd0);
        chk("s1_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) add_vec(i, 1'b1, DW'(i + 2));
        apply_reads("s1");
        last = 16'd5;
        tick();
        chk("s1_rd_hold", 64'(rd_data), 64'(last));
        chk("s1_rd_valid_idle", 64'(rd_valid), 64'd0);

        // DONE ignores further words
        send_word(16'h0099, 1'b0);
        chk("done_ignores_vd", 64'(count), 64'd4);

        // overflow: 7 words after the skip into a 4-deep RAM
        pulse_arm();
        chk("ov_count_cleared", 64'(count), 64'd0);
        for (int i = 0; i < 8; i++) send_word(DW'(16'h10 + i), 1'b0);
        chk("ov_count", 64'(count), 64'd4);
        chk("ov_overflow", 64'(overflow), 64'd1);
        chk("ov_busy", 64'(busy), 64'd1);
        pulse_fin();
        chk("ov_done", 64'(done), 64'd1);
        for (int i = 0; i < 4; i++) add_vec(i, 1'b1, DW'(16'h11 + i));
        apply_reads("ov");

        // fin together with the 3rd stored word
        pulse_arm();
        chk("fw_overflow_cleared", 64'(overflow), 64'd0);
        send_word(16'h0020, 1'b0);
        send_word(16'h0021, 1'b0);
        send_word(16'h0022, 1'b0);
        send_word(16'h0023, 1'b1);
        chk("fw_count", 64'(count), 64'd3);
        chk("fw_done", 64'(done), 64'd1);
        add_vec(2, 1'b1, 16'h0023);
        add_vec(3, 1'b0, 16'h0000);
        apply_reads("fw");

        // restart in the middle of CAPTURE
        pulse_arm();
        send_word(16'h0030, 1'b0);
        send_word(16'h0031, 1'b0);
        send_word(16'h0032, 1'b0);
        chk("re_count_before", 64'(count), 64'd2);
        pulse_arm();
        chk("re_count_after_arm", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) send_word(DW'(16'h40 + i), 1'b0);
        pulse_fin();
        chk("re_count", 64'(count), 64'd3);
        chk("re_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) add_vec(i, 1'b1, DW'(16'h41 + i));
        apply_reads("re");

        // arm wins over fin in the same cycle
        arm = 1'b1; fin = 1'b1;
        tick();
        arm = 1'b0; fin = 1'b0;
        chk("armfin_busy", 64'(busy), 64'd1);
        chk("armfin_done", 64'(done), 64'd0);
        pulse_fin();
        chk("armed_fin_done", 64'(done), 64'd1);
        chk("armed_fin_count", 64'(count), 64'd0);

`ifdef CAP_CHECKSUM_EN
        pulse_arm();
        chk("ck_cleared", 64'(cksum), 64'd0);
        send_word(16'h1234, 1'b0);
        send_word(16'hA5A5, 1'b0);
        send_word(16'h0F0F, 1'b0);
        pulse_fin();
        chk("ck_value", 64'(cksum), 64'hAAAA);
`endif

        // asynchronous reset in the middle of CAPTURE
        pulse_arm();
        send_word(16'h0050, 1'b0);
        send_word(16'h0051, 1'b0);
        chk("ar_count_pre", 64'(count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_rd_data", 64'(rd_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        add_vec(0, 1'b0, 16'h0000);
        apply_reads("ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
